pipeline_cpu: RTL and testbench
===============================

// Module: pipeline_cpu
// PURPOSE
//  5-stage in-order RV32I-subset core (IF/ID/EX/MEM/WB) with internal instruction and data memories.
//  Top of the processor; bench preloads program hex into instance instrMem, array RAM (word-indexed).
//  Exposes only the fetch PC, so the bench detects program end (e.g. pc==32'h100).
// PARAMETERS
//  IMEM_WORDS  1024  instruction RAM depth, 32-bit words
//  DMEM_WORDS  1024  data RAM depth, 32-bit words
//  RESET_PC    32'h0 PC value loaded on reset
// PORTS
//  clk    in   1   single clock; all state updates on rising edge
//  reset  in   1   asynchronous, active-high reset
//  pc     out  32  current IF-stage PC (address of instruction being fetched)
// BEHAVIOUR
//  - Reset (async, active-high): pc=RESET_PC; all pipeline regs hold NOP (32'h00000013, no writes).
//    x1..x31=0; data RAM contents untouched; instruction RAM never written by core.
//  - ISA: LUI AUIPC JAL JALR; BEQ BNE BLT BGE BLTU BGEU; LW SW (word only).
//    ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI; ADD SUB SLL SLT SLTU XOR SRL SRA OR AND.
//    Any other opcode executes as NOP.
//  - x0 reads 0, writes ignored. Shifts use rs2/imm[4:0]. Arithmetic wraps mod 2^32.
//  - IF: instr=RAM[pc[31:2]] (combinational read); pc<=pc+4 each cycle unless stalled/redirected.
//  - Regfile: 2 async read, 1 sync write in WB. Same-cycle WB write to a register read in ID
//    returns the new value (write-through bypass).
//  - Branch/JAL/JALR target and condition resolved in EX.
//    Taken/jump: pc<=target next edge; IF/ID and ID/EX flushed to NOP (2-cycle penalty).
//    Not-taken: no penalty. JALR target=(rs1+imm)&~1. JAL/JALR write pc+4 to rd.
//  - Load-use: LW in EX whose rd!=0 matches ID rs1/rs2 -> hold pc and IF/ID one cycle, bubble into EX.
//  - Data RAM: word index addr[31:2], sync write in MEM, async read; misaligned low bits ignored.
//  - Simultaneous stall and EX redirect: redirect wins (flush overrides stall).
//  - PC wrap at 2^32 natural; fetch beyond IMEM_WORDS returns RAM index modulo depth.
// CONFIGURATION
//  FORWARDING_EN defined: EX operands forwarded from EX/MEM (ALU result) and MEM/WB (result).
//    EX/MEM has priority; rd==0 never forwards. Only LW-use stalls 1 cycle.
//  FORWARDING_EN undefined: no forwarding. ID stalls while rs1/rs2 (nonzero) matches rd of an
//    in-flight writing instr in EX or MEM. WB covered by the regfile bypass.
//  Architectural results identical either way; only cycle counts differ.
// STRUCTURE
//  Shared package/include: opcode/funct3/funct7 constants, ALU op codes, NOP encoding,
//  pipeline-register field widths.
//  Sub-module instr_mem, instance name instrMem, reg [31:0] RAM[0:IMEM_WORDS-1], async read.
//  Regfile, ALU, hazard/forward logic and data RAM stay inline in pipeline_cpu.
// TESTING
//  1 Reset mid-run: assert reset at cycle 7 -> pc==0 immediately (async), regs x1..x31 read 0.
//  2 addi x1,x0,5; addi x2,x1,3; add x3,x1,x2 -> x3==13 (tests forwarding/stall path both builds).
//  3 sw x3,8(x0); lw x4,8(x0); addi x5,x4,1 -> x5==14; exactly 1 stall cycle with FORWARDING_EN.
//  4 beq x1,x1,+12 after addi x1,x0,1 -> two following instrs not committed, target executes.
//  5 jal x1,+0x20 at pc 0x40 -> x1==0x44, next fetched pc==0x60; jalr x0,0(x1) returns to 0x44.
//  6 Full program ending at 0x100 -> pc reaches 32'h100; x0 still 0; no X on pc after reset.

Source files
------------

// File: rtl/pipeline_cpu_pkg.sv
// Shared ISA constants, ALU operation codes and ID/EX control bundle for pipeline_cpu.
package pipeline_cpu_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam int REG_IDX_W = 5;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jal;
        logic       jalr;
        logic       a_pc;
        logic       b_imm;
        alu_op_t    alu_op;
        logic [2:0] funct3;
    } ctrl_t;

    // instr[30] selects SUB/SRA; SUB only exists in the register-register form
    function automatic alu_op_t alu_decode(input logic [2:0] f3, input logic alt, input logic is_reg);
        alu_op_t op;
        case (f3)
            3'b000:  op = (is_reg && alt) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/pipeline_cpu_instr_mem.sv
// Instruction RAM with combinational read; contents are preloaded externally, never written by the core.
module instr_mem #(
    parameter int WORDS = 1024
) (
    input  logic [$clog2(WORDS)-1:0] addr,
    output logic [31:0]              instr
);
    logic [31:0] RAM [0:WORDS-1];

    assign instr = RAM[addr];
endmodule

// File: rtl/pipeline_cpu.sv
// 5-stage RV32I-subset core with internal instruction/data RAM.
// Define FORWARDING_EN to forward EX operands from EX/MEM and MEM/WB instead of stalling.
module pipeline_cpu
    import pipeline_cpu_pkg::*;
#(
    parameter int          IMEM_WORDS = 1024,
    parameter int          DMEM_WORDS = 1024,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] pc
);
    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    logic [31:0] fetch_instr, id_pc, id_instr;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, id_imm, id_a, id_b;
    logic [REG_IDX_W-1:0] id_rs1, id_rs2, id_rd;
    logic        use_rs1, use_rs2, writes_rd;
    ctrl_t       id_ctrl, ex_ctrl;
    logic [31:0] ex_pc, ex_a, ex_b, ex_imm, op_a, op_b, alu_a, alu_b, alu_out, ex_result, target;
    logic [REG_IDX_W-1:0] ex_rd, mem_rd, wb_rd;
    logic        cond, redirect, stall;
    logic [31:0] mem_result, mem_store, mem_load, wb_result;
    logic        mem_read, mem_write;
    logic [31:0] regs [0:31];
    logic [31:0] dmem [0:DMEM_WORDS-1];

    instr_mem #(.WORDS(IMEM_WORDS)) instrMem (
        .addr  (pc[IMEM_AW+1:2]),
        .instr (fetch_instr)
    );

    assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25], id_instr[11:8], 1'b0};
    assign imm_u = {id_instr[31:12], 12'b0};
    assign imm_j = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12], id_instr[20], id_instr[30:21], 1'b0};

    always_comb begin
        id_ctrl        = '0;
        id_ctrl.funct3 = id_instr[14:12];
        id_imm         = imm_i;
        use_rs1        = 1'b0;
        use_rs2        = 1'b0;
        writes_rd      = 1'b0;
        case (id_instr[6:0])
            OP_LUI:    begin writes_rd = 1'b1; id_ctrl.b_imm = 1'b1; id_ctrl.alu_op = ALU_PASS_B; id_imm = imm_u; end
            OP_AUIPC:  begin writes_rd = 1'b1; id_ctrl.a_pc = 1'b1; id_ctrl.b_imm = 1'b1; id_imm = imm_u; end
            OP_JAL:    begin writes_rd = 1'b1; id_ctrl.jal = 1'b1; id_imm = imm_j; end
            OP_JALR:   begin writes_rd = 1'b1; id_ctrl.jalr = 1'b1; use_rs1 = 1'b1; end
            OP_BRANCH: begin id_ctrl.branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; id_imm = imm_b; end
            OP_LOAD: if (id_instr[14:12] == F3_WORD) begin
                writes_rd = 1'b1; id_ctrl.mem_read = 1'b1; use_rs1 = 1'b1; id_ctrl.b_imm = 1'b1;
            end
            OP_STORE: if (id_instr[14:12] == F3_WORD) begin
                id_ctrl.mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; id_ctrl.b_imm = 1'b1; id_imm = imm_s;
            end
            OP_IMM: begin
                writes_rd = 1'b1; use_rs1 = 1'b1; id_ctrl.b_imm = 1'b1;
                id_ctrl.alu_op = alu_decode(id_instr[14:12], id_instr[30], 1'b0);
            end
            OP_REG: begin
                writes_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1;
                id_ctrl.alu_op = alu_decode(id_instr[14:12], id_instr[30], 1'b1);
            end
            default: ;
        endcase
    end

    // Unused source/destination fields collapse to x0 so hazard compares never match them
    assign id_rs1 = use_rs1   ? id_instr[19:15] : '0;
    assign id_rs2 = use_rs2   ? id_instr[24:20] : '0;
    assign id_rd  = writes_rd ? id_instr[11:7]  : '0;

    assign id_a = (id_rs1 == '0) ? '0 : (id_rs1 == wb_rd) ? wb_result : regs[id_rs1];
    assign id_b = (id_rs2 == '0) ? '0 : (id_rs2 == wb_rd) ? wb_result : regs[id_rs2];

`ifdef FORWARDING_EN
    logic [REG_IDX_W-1:0] ex_rs1, ex_rs2;

    assign stall = ex_ctrl.mem_read && (ex_rd != '0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
    assign op_a  = (mem_rd != '0 && mem_rd == ex_rs1) ? mem_result :
                   (wb_rd  != '0 && wb_rd  == ex_rs1) ? wb_result  : ex_a;
    assign op_b  = (mem_rd != '0 && mem_rd == ex_rs2) ? mem_result :
                   (wb_rd  != '0 && wb_rd  == ex_rs2) ? wb_result  : ex_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else if (redirect || stall) begin
            ex_rs1 <= '0;
            ex_rs2 <= '0;
        end else begin
            ex_rs1 <= id_rs1;
            ex_rs2 <= id_rs2;
        end
    end
`else
    assign stall = (ex_rd  != '0 && (ex_rd  == id_rs1 || ex_rd  == id_rs2)) ||
                   (mem_rd != '0 && (mem_rd == id_rs1 || mem_rd == id_rs2));
    assign op_a  = ex_a;
    assign op_b  = ex_b;
`endif

    assign alu_a = ex_ctrl.a_pc  ? ex_pc  : op_a;
    assign alu_b = ex_ctrl.b_imm ? ex_imm : op_b;

    always_comb begin
        alu_out = '0;
        case (ex_ctrl.alu_op)
            ALU_ADD:    alu_out = alu_a + alu_b;
            ALU_SUB:    alu_out = alu_a - alu_b;
            ALU_SLL:    alu_out = alu_a << alu_b[4:0];
            ALU_SLT:    alu_out = {31'b0, $signed(alu_a) < $signed(alu_b)};
            ALU_SLTU:   alu_out = {31'b0, alu_a < alu_b};
            ALU_XOR:    alu_out = alu_a ^ alu_b;
            ALU_SRL:    alu_out = alu_a >> alu_b[4:0];
            ALU_SRA:    alu_out = $signed(alu_a) >>> alu_b[4:0];
            ALU_OR:     alu_out = alu_a | alu_b;
            ALU_AND:    alu_out = alu_a & alu_b;
            ALU_PASS_B: alu_out = alu_b;
            default:    alu_out = '0;
        endcase
    end

    always_comb begin
        cond = 1'b0;
        case (ex_ctrl.funct3)
            F3_BEQ:  cond = (op_a == op_b);
            F3_BNE:  cond = (op_a != op_b);
            F3_BLT:  cond = ($signed(op_a) <  $signed(op_b));
            F3_BGE:  cond = ($signed(op_a) >= $signed(op_b));
            F3_BLTU: cond = (op_a <  op_b);
            F3_BGEU: cond = (op_a >= op_b);
            default: cond = 1'b0;
        endcase
    end

    assign redirect  = (ex_ctrl.branch && cond) || ex_ctrl.jal || ex_ctrl.jalr;
    assign target    = ex_ctrl.jalr ? ((op_a + ex_imm) & ~32'd1) : (ex_pc + ex_imm);
    assign ex_result = (ex_ctrl.jal || ex_ctrl.jalr) ? (ex_pc + 32'd4) : alu_out;
    assign mem_load  = dmem[mem_result[DMEM_AW+1:2]];

    // A taken redirect outranks a stall: the stalled instruction is on the wrong path anyway
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            id_pc      <= '0;
            id_instr   <= NOP;
            ex_pc      <= '0;
            ex_a       <= '0;
            ex_b       <= '0;
            ex_imm     <= '0;
            ex_rd      <= '0;
            ex_ctrl    <= '0;
            mem_rd     <= '0;
            mem_result <= '0;
            mem_store  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            wb_rd      <= '0;
            wb_result  <= '0;
        end else begin
            mem_rd     <= ex_rd;
            mem_result <= ex_result;
            mem_store  <= op_b;
            mem_read   <= ex_ctrl.mem_read;
            mem_write  <= ex_ctrl.mem_write;
            wb_rd      <= mem_rd;
            wb_result  <= mem_read ? mem_load : mem_result;
            if (redirect) begin
                pc       <= target;
                id_instr <= NOP;
                ex_rd    <= '0;
                ex_ctrl  <= '0;
            end else if (stall) begin
                ex_rd    <= '0;
                ex_ctrl  <= '0;
            end else begin
                pc       <= pc + 32'd4;
                id_pc    <= pc;
                id_instr <= fetch_instr;
                ex_pc    <= id_pc;
                ex_a     <= id_a;
                ex_b     <= id_b;
                ex_imm   <= id_imm;
                ex_rd    <= id_rd;
                ex_ctrl  <= id_ctrl;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wb_rd != '0) begin
            regs[wb_rd] <= wb_result;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_write) dmem[mem_result[DMEM_AW+1:2]] <= mem_store;
    end

endmodule

// File: tb/tb_pipeline_cpu.sv
// Directed bench for pipeline_cpu: preloads small programs into instrMem and checks register/memory/PC results.
module tb_pipeline_cpu;

    localparam int OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JALR = 7'b1100111;
    localparam int OP_LOAD = 7'b0000011, OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc;
    int          checks = 0;
    int          errors = 0;

    pipeline_cpu dut (
        .clk   (clk),
        .reset (reset),
        .pc    (pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(int imm, int rs1, int f3, int rd, int op);
        logic [31:0] m, a, f, d, o;
        m = imm; a = rs1; f = f3; d = rd; o = op;
        return {m[11:0], a[4:0], f[2:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_r(int f7, int rs2, int rs1, int f3, int rd);
        logic [31:0] s, b, a, f, d;
        s = f7; b = rs2; a = rs1; f = f3; d = rd;
        return {s[6:0], b[4:0], a[4:0], f[2:0], d[4:0], 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_s(int imm, int rs2, int rs1);
        logic [31:0] m, b, a;
        m = imm; b = rs2; a = rs1;
        return {m[11:5], b[4:0], a[4:0], 3'b010, m[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(int imm, int rs2, int rs1, int f3);
        logic [31:0] m, b, a, f;
        m = imm; b = rs2; a = rs1; f = f3;
        return {m[12], m[10:5], b[4:0], a[4:0], f[2:0], m[4:1], m[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_u(int imm20, int rd, int op);
        logic [31:0] m, d, o;
        m = imm20; d = rd; o = op;
        return {m[19:0], d[4:0], o[6:0]};
    endfunction

    function automatic logic [31:0] enc_j(int imm, int rd);
        logic [31:0] m, d;
        m = imm; d = rd;
        return {m[20], m[10:1], m[11], m[19:12], d[4:0], 7'b1101111};
    endfunction

    task automatic hold_reset();
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 1024; i++) dut.instrMem.RAM[i] = NOP_W;
    endtask

    task automatic put(int addr, logic [31:0] w);
        dut.instrMem.RAM[addr / 4] = w;
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic run_until(input logic [31:0] target, input int max, output int cycles, output bit ok);
        cycles = 0;
        while (pc !== target && cycles < max) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        ok = (pc === target);
    endtask

    task automatic load_arith();
        put(32'h00, enc_i(5, 0, 0, 1, OP_IMM));
        put(32'h04, enc_i(3, 1, 0, 2, OP_IMM));
        put(32'h08, enc_r(0, 2, 1, 0, 3));
    endtask

    task automatic test_reset();
        bit all_zero;
        hold_reset();
        #1;
        checks++;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected %h", pc, 32'h0); end
        load_arith();
        release_reset();
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (dut.regs[1] !== 32'd5) begin errors++; $display("[TB] FAIL pre_reset_x1: got %h expected %h", dut.regs[1], 32'd5); end
        reset = 1'b1;
        #1;
        checks++;
        if (pc !== 32'h0) begin errors++; $display("[TB] FAIL async_reset_pc: got %h expected %h", pc, 32'h0); end
        all_zero = 1'b1;
        for (int i = 1; i < 32; i++) if (dut.regs[i] !== 32'h0) all_zero = 1'b0;
        checks++;
        if (!all_zero) begin errors++; $display("[TB] FAIL async_reset_regs: got nonzero register expected all 0"); end
    endtask

    task automatic test_forwarding();
        int cycles; bit ok; int exp_cycles;
`ifdef FORWARDING_EN
        exp_cycles = 16;
`else
        exp_cycles = 20;
`endif
        hold_reset();
        load_arith();
        release_reset();
        run_until(32'h40, 300, cycles, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL fwd_timeout: got pc %h expected %h", pc, 32'h40); end
        checks++;
        if (cycles != exp_cycles) begin errors++; $display("[TB] FAIL fwd_cycles: got %0d expected %0d", cycles, exp_cycles); end
        checks++;
        if (dut.regs[1] !== 32'd5) begin errors++; $display("[TB] FAIL fwd_x1: got %h expected %h", dut.regs[1], 32'd5); end
        checks++;
        if (dut.regs[2] !== 32'd8) begin errors++; $display("[TB] FAIL fwd_x2: got %h expected %h", dut.regs[2], 32'd8); end
        checks++;
        if (dut.regs[3] !== 32'd13) begin errors++; $display("[TB] FAIL fwd_x3: got %h expected %h", dut.regs[3], 32'd13); end
    endtask

    task automatic test_load_use();
        int cycles; bit ok; int exp_cycles;
`ifdef FORWARDING_EN
        exp_cycles = 17;
`else
        exp_cycles = 24;
`endif
        hold_reset();
        load_arith();
        put(32'h0C, enc_s(8, 3, 0));
        put(32'h10, enc_i(8, 0, 2, 4, OP_LOAD));
        put(32'h14, enc_i(1, 4, 0, 5, OP_IMM));
        release_reset();
        run_until(32'h40, 300, cycles, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL lu_timeout: got pc %h expected %h", pc, 32'h40); end
        checks++;
        if (cycles != exp_cycles) begin errors++; $display("[TB] FAIL lu_cycles: got %0d expected %0d", cycles, exp_cycles); end
        checks++;
        if (dut.dmem[2] !== 32'd13) begin errors++; $display("[TB] FAIL lu_dmem2: got %h expected %h", dut.dmem[2], 32'd13); end
        checks++;
        if (dut.regs[4] !== 32'd13) begin errors++; $display("[TB] FAIL lu_x4: got %h expected %h", dut.regs[4], 32'd13); end
        checks++;
        if (dut.regs[5] !== 32'd14) begin errors++; $display("[TB] FAIL lu_x5: got %h expected %h", dut.regs[5], 32'd14); end
    endtask

    task automatic test_branch();
        int cycles; bit ok;
        logic [31:0] exp_v [0:3];
        int          idx   [0:3];
        exp_v = '{32'd3, 32'd0, 32'd0, 32'd11};
        idx   = '{5, 2, 3, 4};
        hold_reset();
        put(32'h00, enc_i(1, 0, 0, 1, OP_IMM));
        put(32'h04, enc_b(8, 1, 1, 1));
        put(32'h08, enc_i(3, 0, 0, 5, OP_IMM));
        put(32'h0C, enc_b(12, 1, 1, 0));
        put(32'h10, enc_i(7, 0, 0, 2, OP_IMM));
        put(32'h14, enc_i(9, 0, 0, 3, OP_IMM));
        put(32'h18, enc_i(11, 0, 0, 4, OP_IMM));
        release_reset();
        run_until(32'h40, 300, cycles, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL br_timeout: got pc %h expected %h", pc, 32'h40); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (dut.regs[idx[i]] !== exp_v[i]) begin
                errors++;
                $display("[TB] FAIL br_x%0d: got %h expected %h", idx[i], dut.regs[idx[i]], exp_v[i]);
            end
        end
    endtask

    task automatic test_jump();
        int cycles; bit ok;
        logic [31:0] exp_v [0:6];
        int          idx   [0:6];
        exp_v = '{32'h44, 32'd6, 32'd7, 32'd0, 32'd0, 32'd0, 32'd0};
        idx   = '{1, 6, 7, 8, 9, 10, 11};
        hold_reset();
        put(32'h40, enc_j(32'h20, 1));
        put(32'h44, enc_i(6, 0, 0, 6, OP_IMM));
        put(32'h48, enc_i(7, 0, 0, 7, OP_IMM));
        put(32'h4C, enc_j(32'hB4, 0));
        put(32'h50, enc_i(10, 0, 0, 10, OP_IMM));
        put(32'h54, enc_i(11, 0, 0, 11, OP_IMM));
        put(32'h60, enc_i(0, 1, 0, 0, OP_JALR));
        put(32'h64, enc_i(8, 0, 0, 8, OP_IMM));
        put(32'h68, enc_i(9, 0, 0, 9, OP_IMM));
        release_reset();
        run_until(32'h48, 100, cycles, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL jal_reach: got pc %h expected %h", pc, 32'h48); end
        @(posedge clk); #1;
        checks++;
        if (pc !== 32'h60) begin errors++; $display("[TB] FAIL jal_target: got %h expected %h", pc, 32'h60); end
        run_until(32'h68, 20, cycles, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL jalr_reach: got pc %h expected %h", pc, 32'h68); end
        @(posedge clk); #1;
        checks++;
        if (pc !== 32'h44) begin errors++; $display("[TB] FAIL jalr_target: got %h expected %h", pc, 32'h44); end
        run_until(32'h100, 40, cycles, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL jump_end: got pc %h expected %h", pc, 32'h100); end
        repeat (4) @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (dut.regs[idx[i]] !== exp_v[i]) begin
                errors++;
                $display("[TB] FAIL jump_x%0d: got %h expected %h", idx[i], dut.regs[idx[i]], exp_v[i]);
            end
        end
    endtask

    task automatic test_full_program();
        int cycles; bit ok;
        logic [31:0] exp_regs [0:26];
        exp_regs = '{32'h0, 32'h12345000, 32'h1004, 32'hFFFFFFF8, 32'h3, 32'hB, 32'hFFFFFFFF,
                     32'h1FFFFFFF, 32'h18, 32'h1, 32'h0, 32'hFFFFFFFB, 32'hFFFFFFFB, 32'h0,
                     32'h1, 32'h1, 32'hF3, 32'h103, 32'hF8, 32'hC0000000, 32'hFC000000,
                     32'h0C000000, 32'h0, 32'h2, 32'h4, 32'h0, 32'h12346004};
        hold_reset();
        #1;
        checks++;
        if ($isunknown(pc)) begin errors++; $display("[TB] FAIL pc_known: got %h expected %h", pc, 32'h0); end
        put(32'h00, enc_u(32'h12345, 1, OP_LUI));
        put(32'h04, enc_u(1, 2, OP_AUIPC));
        put(32'h08, enc_i(-8, 0, 0, 3, OP_IMM));
        put(32'h0C, enc_i(3, 0, 0, 4, OP_IMM));
        put(32'h10, enc_r(32, 3, 4, 0, 5));
        put(32'h14, enc_r(32, 4, 3, 5, 6));
        put(32'h18, enc_r(0, 4, 3, 5, 7));
        put(32'h1C, enc_r(0, 4, 4, 1, 8));
        put(32'h20, enc_r(0, 4, 3, 2, 9));
        put(32'h24, enc_r(0, 4, 3, 3, 10));
        put(32'h28, enc_r(0, 4, 3, 4, 11));
        put(32'h2C, enc_r(0, 4, 3, 6, 12));
        put(32'h30, enc_r(0, 4, 3, 7, 13));
        put(32'h34, enc_i(-7, 3, 2, 14, OP_IMM));
        put(32'h38, enc_i(-1, 4, 3, 15, OP_IMM));
        put(32'h3C, enc_i(32'hF0, 4, 4, 16, OP_IMM));
        put(32'h40, enc_i(32'h100, 4, 6, 17, OP_IMM));
        put(32'h44, enc_i(32'hFF, 3, 7, 18, OP_IMM));
        put(32'h48, enc_i(30, 4, 1, 19, OP_IMM));
        put(32'h4C, enc_i(32'h404, 19, 5, 20, OP_IMM));
        put(32'h50, enc_i(4, 19, 5, 21, OP_IMM));
        put(32'h54, enc_i(5, 0, 0, 0, OP_IMM));
        put(32'h58, enc_b(8, 4, 3, 4));
        put(32'h5C, enc_i(1, 0, 0, 22, OP_IMM));
        put(32'h60, enc_b(8, 4, 3, 5));
        put(32'h64, enc_i(2, 0, 0, 23, OP_IMM));
        put(32'h68, enc_b(8, 4, 3, 6));
        put(32'h6C, enc_i(4, 0, 0, 24, OP_IMM));
        put(32'h70, enc_b(8, 4, 3, 7));
        put(32'h74, enc_i(5, 0, 0, 25, OP_IMM));
        put(32'h78, enc_r(0, 2, 1, 0, 26));
        release_reset();
        run_until(32'h100, 400, cycles, ok);
        checks++;
        if (!ok) begin errors++; $display("[TB] FAIL full_end: got pc %h expected %h", pc, 32'h100); end
        for (int i = 0; i < 27; i++) begin
            checks++;
            if (dut.regs[i] !== exp_regs[i]) begin
                errors++;
                $display("[TB] FAIL full_x%0d: got %h expected %h", i, dut.regs[i], exp_regs[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_jump();
        test_full_program();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
